// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 (modified Booth) multiplier for the FPU mantissa path.
// Retires two multiplier bits per cycle; start/busy/done handshake, product held until next start.
module booth_radix4_mult #(
   parameter int N = 24
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           start,
   input  logic           signed_mode,
   input  logic [N-1:0]   M,
   input  logic [N-1:0]   Q,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] R
);

   localparam int W    = N + 2;
   localparam int ITER = N / 2 + 1;
   localparam int CW   = $clog2(ITER + 1);
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   generate
      if ((N < 4) || ((N % 2) != 0)) begin : g_bad_n
         $error("booth_radix4_mult: N must be even and >= 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t              state;
   logic signed [W:0]   acc;
   logic signed [W-1:0] mx;
   logic [W-1:0]        qx;
   logic                q_1;
   logic [CW-1:0]       cnt;

   logic [2:0]          trip;
   logic signed [W:0]   addend;
   logic signed [W:0]   acc_next;

   // Two extra bits let an unsigned N-bit operand recode as a positive W-bit value.
   function automatic logic [W-1:0] extend(input logic [N-1:0] x, input logic sm);
      return sm ? {{2{x[N-1]}}, x} : {2'b00, x};
   endfunction

   function automatic logic signed [W:0] booth_addend(input logic [2:0] tr,
                                                     input logic signed [W-1:0] m);
      logic signed [W:0] m1;
      m1 = {m[W-1], m};
      case (tr)
         3'b001, 3'b010: booth_addend = m1;
         3'b011:         booth_addend = m1 <<< 1;
         3'b100:         booth_addend = -(m1 <<< 1);
         3'b101, 3'b110: booth_addend = -m1;
         default:        booth_addend = '0;
      endcase
   endfunction

   always_comb begin
      trip     = {qx[1:0], q_1};
      addend   = booth_addend(trip, mx);
      acc_next = acc + addend;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         R     <= '0;
         acc   <= '0;
         mx    <= '0;
         qx    <= '0;
         q_1   <= 1'b0;
         cnt   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mx    <= $signed(extend(M, signed_mode));
                  acc   <= '0;
                  qx    <= extend(Q, signed_mode);
                  q_1   <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               // Arithmetic shift of {acc_next, qx, q_1} right by two.
               acc <= {{2{acc_next[W]}}, acc_next[W:2]};
               qx  <= {acc_next[1:0], qx[W-1:2]};
               q_1 <= qx[1];
               cnt <= cnt + CW'(1);
               if (cnt == LAST) state <= FINISH;
            end
            FINISH: begin
               R     <= {acc[N-3:0], qx};
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Bench for booth_radix4_mult: N=8 and N=24 instances checked against an arithmetic product model.
`timescale 1ns/1ps
module tb_booth_radix4_mult;

   localparam int ITER8  = 5;
   localparam int ITER24 = 13;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start8, sm8, busy8, done8;
   logic [7:0]  m8, q8;
   logic [15:0] r8;
   logic        start24, sm24, busy24, done24;
   logic [23:0] m24, q24;
   logic [47:0] r24;

   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] last_r8;

   always #5 clk = ~clk;

   booth_radix4_mult #(.N(8)) dut8 (
      .clk(clk), .rstn(rstn), .start(start8), .signed_mode(sm8),
      .M(m8), .Q(q8), .busy(busy8), .done(done8), .R(r8));

   booth_radix4_mult #(.N(24)) dut24 (
      .clk(clk), .rstn(rstn), .start(start24), .signed_mode(sm24),
      .M(m24), .Q(q24), .busy(busy24), .done(done24), .R(r24));

   function automatic logic [63:0] ref_prod(input int n, input logic sm,
                                            input logic [31:0] m, input logic [31:0] q);
      longint a, b;
      logic [63:0] p, mask;
      a = longint'(m);
      b = longint'(q);
      if (sm && m[n-1]) a = a - (longint'(1) <<< n);
      if (sm && q[n-1]) b = b - (longint'(1) <<< n);
      p    = 64'(a * b);
      mask = (64'd1 << (2 * n)) - 64'd1;
      return p & mask;
   endfunction

   function automatic logic [31:0] pick(input int n);
      logic [31:0] full;
      full = (32'd1 << n) - 32'd1;
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return full;
         2:       return 32'd1 << (n - 1);
         3:       return full >> 1;
         default: return $urandom & full;
      endcase
   endfunction

   // Starts one operation from IDLE; returns product, cycles from accept to done, busy cycles.
   task automatic run_op8(input logic sm, input logic [7:0] m, input logic [7:0] q,
                          output logic [15:0] r, output int lat, output int bcyc);
      sm8 = sm; m8 = m; q8 = q; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      lat = -1; bcyc = 0;
      for (int i = 1; i <= 40; i++) begin
         if (busy8) bcyc++;
         @(posedge clk); #1;
         if (done8) begin lat = i; break; end
      end
      r = r8;
   endtask

   task automatic run_op24(input logic sm, input logic [23:0] m, input logic [23:0] q,
                           output logic [47:0] r, output int lat);
      sm24 = sm; m24 = m; q24 = q; start24 = 1'b1;
      @(posedge clk); #1;
      start24 = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done24) begin lat = i; break; end
      end
      r = r24;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      start8 = 0; sm8 = 0; m8 = '0; q8 = '0;
      start24 = 0; sm24 = 0; m24 = '0; q24 = '0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL reset_busy8: got %b expected 0", busy8); end
      n_cmp++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL reset_done8: got %b expected 0", done8); end
      n_cmp++; if (r8 !== 16'h0)   begin n_bad++; $display("FAIL reset_R8: got %h expected 0", r8); end
      n_cmp++; if (busy24 !== 1'b0) begin n_bad++; $display("FAIL reset_busy24: got %b expected 0", busy24); end
      n_cmp++; if (done24 !== 1'b0) begin n_bad++; $display("FAIL reset_done24: got %b expected 0", done24); end
      n_cmp++; if (r24 !== 48'h0)   begin n_bad++; $display("FAIL reset_R24: got %h expected 0", r24); end
      rstn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL idle_busy8: got %b expected 0", busy8); end
      last_r8 = 16'h0;
   endtask

   task automatic test_directed();
      logic        tsm[6];
      logic [7:0]  tm[6], tq[6];
      logic [15:0] texp[6];
      logic [15:0] r;
      logic [47:0] r_w;
      int lat, bcyc;
      tsm  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      tm   = '{8'hFD, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'h00};
      tq   = '{8'h05, 8'hFF, 8'hFF, 8'h80, 8'h7F, 8'h80};
      texp = '{16'hFFF1, 16'hFE01, 16'h0001, 16'h4000, 16'hC080, 16'h0000};
      for (int i = 0; i < 6; i++) begin
         run_op8(tsm[i], tm[i], tq[i], r, lat, bcyc);
         n_cmp++; if (r !== texp[i]) begin n_bad++; $display("FAIL dir_R[%0d]: got %h expected %h", i, r, texp[i]); end
         n_cmp++; if (lat !== ITER8 + 1) begin n_bad++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, ITER8 + 1); end
         n_cmp++; if (bcyc !== ITER8 + 1) begin n_bad++; $display("FAIL dir_busy_cycles[%0d]: got %0d expected %0d", i, bcyc, ITER8 + 1); end
         n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL dir_busy_at_done[%0d]: got %b expected 0", i, busy8); end
         last_r8 = texp[i];
      end
      // Product must survive idle cycles with changing inputs.
      repeat (4) begin
         m8 = 8'($urandom); q8 = 8'($urandom);
         @(posedge clk); #1;
         n_cmp++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL hold_done: got %b expected 0", done8); end
         n_cmp++; if (r8 !== last_r8) begin n_bad++; $display("FAIL hold_R: got %h expected %h", r8, last_r8); end
      end
      run_op24(1'b1, 24'hFFFFFF, 24'hFFFFFF, r_w, lat);
      n_cmp++; if (r_w !== 48'h1) begin n_bad++; $display("FAIL dir24_signed: got %h expected 000000000001", r_w); end
      n_cmp++; if (lat !== ITER24 + 1) begin n_bad++; $display("FAIL dir24_latency: got %0d expected %0d", lat, ITER24 + 1); end
      run_op24(1'b0, 24'hFFFFFF, 24'hFFFFFF, r_w, lat);
      n_cmp++; if (r_w !== 48'hFFFFFE000001) begin n_bad++; $display("FAIL dir24_unsigned: got %h expected fffffe000001", r_w); end
      run_op24(1'b1, 24'h800000, 24'h800000, r_w, lat);
      n_cmp++; if (r_w !== 48'h400000000000) begin n_bad++; $display("FAIL dir24_minmin: got %h expected 400000000000", r_w); end
   endtask

   // start held high, operands and mode scrambled every cycle.
   task automatic test_back_to_back();
      logic        m_idle, mbusy, mdone, got;
      logic [15:0] pend, mr;
      logic [63:0] full;
      int cd;
      m_idle = 1'b1; mbusy = 1'b0; mdone = 1'b0; cd = 0;
      pend = '0; mr = last_r8;
      start8 = 1'b1; sm8 = 1'($urandom); m8 = 8'($urandom); q8 = 8'($urandom);
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         if (m_idle) begin
            full   = ref_prod(8, sm8, 32'(m8), 32'(q8));
            pend   = full[15:0];
            m_idle = 1'b0; mbusy = 1'b1; mdone = 1'b0; cd = ITER8 + 1;
         end else begin
            cd--;
            if (cd == 0) begin
               mr = pend; mdone = 1'b1; mbusy = 1'b0; m_idle = 1'b1;
            end else begin
               mdone = 1'b0;
            end
         end
         #1;
         n_cmp++; if (done8 !== mdone) begin n_bad++; $display("FAIL b2b_done[%0d]: got %b expected %b", c, done8, mdone); end
         n_cmp++; if (busy8 !== mbusy) begin n_bad++; $display("FAIL b2b_busy[%0d]: got %b expected %b", c, busy8, mbusy); end
         n_cmp++; if (r8 !== mr) begin n_bad++; $display("FAIL b2b_R[%0d]: got %h expected %h", c, r8, mr); end
         sm8 = 1'($urandom); m8 = 8'($urandom); q8 = 8'($urandom);
      end
      start8 = 1'b0;
      if (!m_idle) begin
         got = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done8) begin got = 1'b1; break; end
         end
         n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL b2b_drain_done: got %b expected 1", got); end
         mr = pend;
      end
      n_cmp++; if (r8 !== mr) begin n_bad++; $display("FAIL b2b_final_R: got %h expected %h", r8, mr); end
      last_r8 = mr;
   endtask

   task automatic test_reset_mid_op();
      logic        saw_done;
      logic [15:0] r;
      logic [63:0] full;
      int lat, bcyc;
      sm8 = 1'b1; m8 = 8'h9C; q8 = 8'h37; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (busy8 !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_before: got %b expected 1", busy8); end
      #2 rstn = 1'b0;
      #1;
      n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL rmid_busy_async: got %b expected 0", busy8); end
      n_cmp++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL rmid_done_async: got %b expected 0", done8); end
      n_cmp++; if (r8 !== 16'h0) begin n_bad++; $display("FAIL rmid_R_async: got %h expected 0", r8); end
      @(posedge clk); #1;
      rstn = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done8) saw_done = 1'b1;
      end
      n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL rmid_no_done: got %b expected 0", saw_done); end
      n_cmp++; if (r8 !== 16'h0) begin n_bad++; $display("FAIL rmid_R_after: got %h expected 0", r8); end
      n_cmp++; if (r24 !== 48'h0) begin n_bad++; $display("FAIL rmid_R24_after: got %h expected 0", r24); end
      run_op8(1'b1, 8'h9C, 8'h37, r, lat, bcyc);
      full = ref_prod(8, 1'b1, 32'h9C, 32'h37);
      n_cmp++; if (r !== full[15:0]) begin n_bad++; $display("FAIL rmid_recover_R: got %h expected %h", r, full[15:0]); end
      n_cmp++; if (lat !== ITER8 + 1) begin n_bad++; $display("FAIL rmid_recover_lat: got %0d expected %0d", lat, ITER8 + 1); end
      last_r8 = full[15:0];
   endtask

   task automatic test_random8(input int nops);
      logic        sm;
      logic [7:0]  m, q;
      logic [15:0] r;
      logic [63:0] full;
      int lat, bcyc;
      for (int k = 0; k < nops; k++) begin
         sm = 1'($urandom); m = 8'(pick(8)); q = 8'(pick(8));
         run_op8(sm, m, q, r, lat, bcyc);
         full = ref_prod(8, sm, 32'(m), 32'(q));
         n_cmp++; if (r !== full[15:0]) begin n_bad++; $display("FAIL rnd8_R: sm=%b M=%h Q=%h got %h expected %h", sm, m, q, r, full[15:0]); end
         n_cmp++; if (lat !== ITER8 + 1) begin n_bad++; $display("FAIL rnd8_latency: got %0d expected %0d", lat, ITER8 + 1); end
      end
   endtask

   task automatic test_random24(input int nops);
      logic        sm;
      logic [23:0] m, q;
      logic [47:0] r;
      logic [63:0] full;
      int lat;
      for (int k = 0; k < nops; k++) begin
         sm = 1'($urandom); m = 24'(pick(24)); q = 24'(pick(24));
         run_op24(sm, m, q, r, lat);
         full = ref_prod(24, sm, 32'(m), 32'(q));
         n_cmp++; if (r !== full[47:0]) begin n_bad++; $display("FAIL rnd24_R: sm=%b M=%h Q=%h got %h expected %h", sm, m, q, r, full[47:0]); end
         n_cmp++; if (lat !== ITER24 + 1) begin n_bad++; $display("FAIL rnd24_latency: got %0d expected %0d", lat, ITER24 + 1); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid_op();
      fork
         test_random8(2500);
         test_random24(2500);
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/booth_radix4_mult.md
Name: booth_radix4_mult

Overview:
- Parametrised sequential Booth multiplier for the mantissa datapath of the floating-point unit.
- Uses radix-4 (modified Booth) recoding, so it retires 2 multiplier bits per cycle.
- Accepts signed (two's-complement) or unsigned operands, selected per operation.
- Uses a start/busy/done handshake and holds the product until the next accepted start.

Parameters:
- N, 24, operand width in bits. Must be even and ≥ 4; elaboration fails otherwise.
- ITER, N/2+1 (derived localparam, not overridable), number of recoding iterations.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  request a multiply. Sampled only in IDLE.
- signed_mode  input  1  1 = operands are two's-complement; 0 = operands are unsigned. Sampled with start.
- M  input  N  multiplicand. Sampled with start.
- Q  input  N  multiplier. Sampled with start.
- busy  output  1  high from the accepting edge until done is asserted.
- done  output  1  one-cycle pulse when R is valid.
- R  output  2N  product. Held stable until the next accepted start.

Behaviour:
- Reset (asynchronous, rstn low):
  - state = IDLE.
  - busy = 0, done = 0, R = 0.
  - Accumulator, multiplier register and iteration counter all cleared.
  - Reset mid-operation aborts the operation. No done is produced and R reads 0 after reset.
- Internal width: W = N+2.
  - Operands are extended to W bits: sign-extended if signed_mode = 1, zero-extended otherwise.
  - This extension lets unsigned N-bit operands recode correctly.
- States: IDLE, RUN, FINISH.
- IDLE:
  - When start = 1, the rising edge latches the extended M into Mx and loads {A = 0, Qx = extended Q, q_1 = 0}.
  - The same edge sets cnt = 0, busy = 1 and state = RUN.
  - When start = 0, the block stays in IDLE.
- RUN, one iteration per cycle:
  - Recode triplet {Qx[1], Qx[0], q_1}:
    - 000 or 111 → +0
    - 001 or 010 → +Mx
    - 011 → +2Mx
    - 100 → −2Mx
    - 101 or 110 → −Mx
  - A_next = A + digit·Mx, computed at W+1 bits to absorb the ±2Mx overflow.
  - Then arithmetic-shift the concatenation {A_next, Qx, q_1} right by 2 (the sign bit of A_next replicates).
  - cnt increments each iteration. After iteration cnt = ITER−1, state = FINISH.
- FINISH:
  - R = low 2N bits of the {A, Qx} product.
  - done = 1 for exactly this one cycle; busy = 0 on the same edge; state = IDLE.
- Latency:
  - Accepting edge k; iterations at edges k+1 … k+ITER.
  - done and R are valid after edge k+ITER+1.
  - For N=8: 6 cycles. For N=24: 14 cycles.
  - Throughput: a new start is accepted in the cycle after done (IDLE). Back-to-back operations therefore give ITER+2 cycles per product.
- start while busy = 1 is ignored. Inputs changing while busy have no effect on the running operation.
- R keeps its last value through IDLE and changes only at a FINISH edge (or reset).
- Arithmetic correctness:
  - The exact product always fits in 2N bits.
  - Signed range: −2^(N−1)·−2^(N−1) = 2^(2N−2) fits.
  - Unsigned maximum: (2^N−1)^2 < 2^(2N).
  - No saturation or overflow flag.
- The counter width is $clog2(ITER+1). No combinational path from any input to any output.

Test Plan:
- N=8, signed_mode=1, M=0xFD (−3), Q=0x05 → done 6 cycles after the start edge, R=0xFFF1 (−15); busy high for exactly 6 cycles.
- N=8, signed_mode=0, M=0xFF, Q=0xFF → R=0xFE01 (65025). Then signed_mode=1 with the same operands → R=0x0001.
- N=8 signed corner cases:
  - M=0x80, Q=0x80 → R=0x4000.
  - M=0x80, Q=0x7F → R=0xC080.
  - M=0x00, Q=0x80 → R=0x0000.
- Hold start high continuously and toggle M/Q during RUN:
  - Only the operands latched at the accepting edge are used.
  - Next accept happens on the cycle after done.
  - R stays stable between done pulses.
- Deassert rstn during iteration 3 of an operation:
  - busy, done and R go to 0 immediately (asynchronously).
  - No done pulse occurs.
  - A subsequent start computes correctly.
- Random regression, N=24 and N=8, both modes, ≥10k operands: R matches the reference product and latency is always ITER+1 cycles.
